// File: rtl/spi_regif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_regif_pkg
// Purpose  : Shared FSM state type and command-byte layout for spi_slave_regif.
// Revision : 1.0
// ============================================================================
package spi_regif_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        RD_FETCH = 3'd2,
        DATA     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int CMD_W      = 8;
    localparam int CMD_WR_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Synchronizes one asynchronous SPI pin into clk and flags its edges.
// Revision : 1.0
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~hist_q;
    assign fall     = ~sync_out & hist_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_regif
// Purpose  : Oversampled SPI mode-0 slave producing register read/write strobes.
// Revision : 1.0
// ============================================================================
module spi_slave_regif
    import spi_regif_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              MOSI,
    input  logic              SS,
    output logic              MISO,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rd_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_MAX = (DATA_W > CMD_W) ? DATA_W : CMD_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic sclk_sync, sclk_rise, sclk_fall;
    logic ss_sync, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_in(SCLK),
        .sync_out(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .rst(rst), .async_in(SS),
        .sync_out(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(MOSI),
        .sync_out(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_sync, mosi_rise, mosi_fall};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rx_shift;

    assign rx_shift = {rx_q[DATA_W-2:0], mosi_sync};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end
            CMD: begin
                if (ss_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CMD_W - 1)) begin
                        addr_d  = rx_shift[ADDR_W-1:0];
                        is_wr_d = rx_shift[CMD_WR_BIT];
                        cnt_d   = '0;
                        rx_d    = '0;
                        if (rx_shift[CMD_WR_BIT]) begin
                            state_d = DATA;
                        end else begin
                            rd_en_d = 1'b1;
                            state_d = RD_FETCH;
                        end
                    end
                end
            end
            RD_FETCH: begin
                if (ss_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tx_d    = reg_rd_data;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ss_rise) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                        if (is_wr_q) begin
                            wr_en_d   = 1'b1;
                            wr_data_d = rx_shift;
                        end
                    end
                // The command byte's trailing fall lands here too; only falls
                // after a data-phase rise may advance the TX word.
                end else if (sclk_fall && !is_wr_q && cnt_q != '0) begin
                    tx_d = {tx_q[DATA_W-2:0], 1'b0};
                end
            end
            DONE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MISO        = (!ss_sync && state_q == DATA && !is_wr_q) ? tx_q[DATA_W-1] : 1'b0;
    assign reg_addr    = addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_en   = rd_en_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_regif
// Purpose  : Randomized scoreboard bench for spi_slave_regif (SCLK = clk/8).
// Revision : 1.0
// ============================================================================
module tb_spi_slave_regif;

    localparam int HALF = 40;   // half SCLK period = 4 clk periods

    typedef struct {
        int         kind;       // 0 write, 1 read, 2 frame error
        logic [6:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SS = 1'b1;
    logic        MISO;
    logic [6:0]  reg_addr;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data = 16'h0;
    logic        frame_err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          mon_kind;
    logic [15:0] mem [128];

    spi_slave_regif dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Register-file responder: data is valid only in the clk right after the strobe.
    always @(negedge clk) begin
        if (reg_rd_en) reg_rd_data = mem[reg_addr];
        else           reg_rd_data = 16'($urandom);
    end

    // Monitor: every strobe or error pulse must match the next expected event.
    always @(negedge clk) begin
        if (reg_wr_en || reg_rd_en || frame_err) begin
            check("strobe_exclusive", {31'd0, reg_wr_en & reg_rd_en}, 32'd0);
            mon_kind = frame_err ? 2 : (reg_rd_en ? 1 : 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d addr %h, expected none at %0t",
                         mon_kind, reg_addr, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                if (mon_e.kind != 2) check("event_addr", 32'(reg_addr), 32'(mon_e.addr));
                if (mon_e.kind == 0) check("wr_data", 32'(reg_wr_data), 32'(mon_e.data));
            end
        end
    end

    task automatic push(input int kind, input logic [6:0] addr, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drives SS low and nbits+extra SCLK pulses; leaves SS low.
    task automatic frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits,
                         input int extra, output logic [15:0] rx);
        rx = '0;
        @(posedge clk);
        #2;
        SS = 1'b0;
        #HALF;
        for (int i = 0; i < nbits + extra; i++) begin
            if (i < 8)       MOSI = cmd[7-i];
            else if (i < 24) MOSI = data[23-i];
            else             MOSI = 1'($urandom);
            if (i == 8) check("busy_mid_frame", {31'd0, busy}, 32'd1);
            #HALF;
            SCLK = 1'b1;
            if (i >= 8 && i < 24) rx = {rx[14:0], MISO};
            #HALF;
            SCLK = 1'b0;
        end
        #HALF;
    endtask

    task automatic end_frame();
        SS   = 1'b1;
        MOSI = 1'b0;
        #(2 * HALF);
        check("miso_idle", {31'd0, MISO}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic wr_frame(input logic [6:0] addr, input logic [15:0] data, input int extra);
        logic [15:0] rx;
        mem[addr] = data;
        push(0, addr, data);
        frame({1'b1, addr}, data, 24, extra, rx);
        end_frame();
    endtask

    task automatic rd_frame(input logic [6:0] addr);
        logic [15:0] rx;
        logic [15:0] want;
        want = mem[addr];
        push(1, addr, 16'h0);
        frame({1'b0, addr}, 16'h0, 24, 0, rx);
        check("miso_word", 32'(rx), 32'(want));
        end_frame();
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        check("rst_miso",    {31'd0, MISO},       32'd0);
        check("rst_addr",    32'(reg_addr),       32'd0);
        check("rst_wr_en",   {31'd0, reg_wr_en},  32'd0);
        check("rst_wr_data", 32'(reg_wr_data),    32'd0);
        check("rst_rd_en",   {31'd0, reg_rd_en},  32'd0);
        check("rst_err",     {31'd0, frame_err},  32'd0);
        check("rst_busy",    {31'd0, busy},       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rx;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);

        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        check_reset_state();
        repeat (8) @(posedge clk);

        // Plain write and plain read
        wr_frame(7'h05, 16'hBEEF, 0);
        mem[7'h12] = 16'hA5C3;
        rd_frame(7'h12);

        // SS rises after 12 bits of a write: abort with a single error pulse
        push(2, 7'h0, 16'h0);
        frame(8'h83, 16'h0000, 12, 0, rx);
        end_frame();

        // Extra bits after the data word are ignored
        wr_frame(7'h01, 16'h1234, 4);

        // Reset in the middle of a write's data phase
        frame(8'h8A, 16'hFFFF, 14, 0, rx);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        check_reset_state();
        SS = 1'b1;
        #(2 * HALF);
        wr_frame(7'h0A, 16'h0F0F, 0);

        // Back-to-back write then read of the same register
        wr_frame(7'h10, 16'h5555, 0);
        rd_frame(7'h10);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            logic [6:0]  a;
            logic [15:0] d;
            a = 7'($urandom);
            d = 16'($urandom);
            if ($urandom_range(1, 0) == 1) wr_frame(a, d, $urandom_range(2, 0));
            else                            rd_frame(a);
        end

        repeat (20) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_regif.md
Name: spi_slave_regif

Overview:
- SPI slave front end that turns host SPI frames into single-cycle register-file read/write strobes in the `clk` domain.
- Sits directly upstream of the controller/regfile path and is the only consumer of the `SCLK`/`MOSI`/`SS` pins; drives `MISO`.
- Oversamples all SPI pins with `clk`; `SCLK` is never used as a clock.
- Requires `clk` frequency ≥ 8× `SCLK` frequency.

Parameters:
- ADDR_W, 7: register address width; also the number of address bits in the command byte.
- DATA_W, 16: register data width = data-phase bit count.
- SYNC_STAGES, 2: synchronizer flops per SPI input pin (minimum 2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- SCLK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to clk.
- MOSI  in  1  SPI data in, MSB first.
- SS  in  1  slave select, active low.
- MISO  out  1  SPI data out, MSB first; 0 whenever SS is high.
- reg_addr  out  ADDR_W  address for the current read/write.
- reg_wr_en  out  1  one-clk write strobe.
- reg_wr_data  out  DATA_W  write data; valid while reg_wr_en=1.
- reg_rd_en  out  1  one-clk read strobe.
- reg_rd_data  in  DATA_W  read data; sampled exactly 1 clk after reg_rd_en.
- frame_err  out  1  one-clk pulse when SS rises mid-frame.
- busy  out  1  high from SS-fall detection until return to IDLE.

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, state IDLE, shift registers and counters cleared. Reset mid-frame discards the frame with no strobes. After reset, a frame is accepted only from a fresh SS fall.
- Input conditioning:
  - Each pin passes through SYNC_STAGES flops, then one history flop.
  - sclk_rise, sclk_fall, ss_fall and ss_rise are single-clk pulses.
  - Pin-to-event latency is SYNC_STAGES+1 clk.
- Frame format:
  - Command byte: bit7 = 1 for write, 0 for read; bits[ADDR_W-1:0] = address.
  - Then DATA_W data bits, for 8+DATA_W bits in total.
  - MOSI is sampled on sclk_rise.
- FSM states IDLE, CMD, RD_FETCH, DATA, DONE:
  - IDLE: on ss_fall → CMD, bit counter = 0, busy = 1.
  - CMD: shift MOSI on each sclk_rise. On the 8th rise, latch reg_addr. Read: pulse reg_rd_en in the same cycle, → RD_FETCH. Write: → DATA.
  - RD_FETCH: one clk. Load reg_rd_data into the TX shift register, → DATA.
  - DATA:
    - Write: shift MOSI on each sclk_rise. On the DATA_W-th rise, drive reg_wr_data = shifted word and pulse reg_wr_en for 1 clk, → DONE.
    - Read: MISO = TX MSB. Shift TX left on each sclk_fall; the first shift occurs on the fall following the first data-phase rise. After the DATA_W-th sclk_rise, → DONE.
  - DONE: ignore all further SCLK edges and extra bits. On ss_rise → IDLE, busy = 0.
- MISO timing: the first data-phase bit must be on MISO before the first data-phase rise. At the minimum 8× ratio this is met because reg_rd_data is loaded 2 clk after the 8th-rise event.
- SS rise in CMD, RD_FETCH or DATA: abort, pulse frame_err for 1 clk, no reg_wr_en, → IDLE. A reg_rd_en already issued stands; it has no side effects.
- ss_fall and ss_rise in the same clk cannot occur because synchronized SS is a single bit.
- sclk edges while SS is high are ignored.
- reg_wr_en and reg_rd_en are never high in the same clk, and at most one strobe is issued per frame.
- Back-to-back frames: a new ss_fall is accepted in the clk after the return to IDLE.

Decomposition:
- spi_regif_pkg holds:
  - state_t enum (IDLE, CMD, RD_FETCH, DATA, DONE)
  - CMD_W = 8
  - CMD_WR_BIT = 7
- Sub-module spi_sync_edge:
  - Parameter SYNC_STAGES.
  - Inputs clk, rst, async_in. Outputs sync_out, rise, fall.
  - Instantiated for SCLK, SS and MOSI; only sync_out is used for MOSI.
- FSM, shift registers and bit counter stay in the top module.

Test Plan:
1. Write frame with command 0x85 and data 0xBEEF, SCLK = clk/8 → exactly one reg_wr_en with reg_addr=0x05, reg_wr_data=0xBEEF; frame_err stays 0.
2. Read frame with command 0x12, reg_rd_data=0xA5C3 → one reg_rd_en with reg_addr=0x12; MISO sampled on data-phase rises yields 0xA5C3; MISO=0 after SS rises.
3. Write command 0x83, SS raised after 12 total bits → no reg_wr_en; one frame_err pulse; busy returns to 0.
4. Write 0x81 with data 0x1234, then 4 extra SCLK pulses before SS rises → single reg_wr_en with data 0x1234; extra bits ignored.
5. rst asserted mid data phase of a write, then a full write of 0x8A/0x0F0F → no strobe from the first frame; second frame gives one write with addr 0x0A, data 0x0F0F.
6. Back-to-back frames with SS high for one SCLK period (write 0x90/0x5555, then read 0x10 returning 0x5555) → both strobes issued; MISO shifts out 0x5555.
